cache_2way_ctrl: RTL and testbench

Controller that drives the 2-way set-associative data/tag storage array (`Cache2Way`) from a single CPU load/store port. It performs tag lookup, hit/miss decision, LRU victim choice and line refill from memory, with a write-through, no-write-allocate policy. It sits between the CPU memory stage and the storage array and next-level memory. It also owns the per-set valid and LRU state, which the storage array does not hold.

---
 rtl/cache_pkg.sv | 46 ++++
 rtl/cache_valid_lru.sv | 38 +++
 rtl/cache_2way_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cache_2way_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, address field layout, FSM states and request payload
// for the 2-way set-associative cache controller.
package cache_pkg;

    localparam int unsigned ADDR_WIDTH       = 5;
    localparam int unsigned TAG_BITS         = 23;
    localparam int unsigned WHOLE_DATA_WIDTH = 128;
    localparam int unsigned BANK_DATA_WIDTH  = 32;
    localparam int unsigned DATA_WORD_NUM    = 4;
    localparam int unsigned DATA_BYTE_NUM    = 4;
    localparam int unsigned CACHE_WAY_NUM    = 2;
    localparam int unsigned SET_NUM          = 32;

    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned WORD_OFF_W = 2;
    localparam int unsigned INDEX_LSB  = BYTE_OFF_W + WORD_OFF_W;
    localparam int unsigned TAG_LSB    = INDEX_LSB + ADDR_WIDTH;

    localparam logic [CACHE_WAY_NUM-1:0] WAY0 = 2'b01;
    localparam logic [CACHE_WAY_NUM-1:0] WAY1 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL,
        ST_FILL,
        ST_WRMEM
    } state_e;

    typedef struct packed {
        logic [TAG_BITS-1:0]        tag;
        logic [ADDR_WIDTH-1:0]      index;
        logic [WORD_OFF_W-1:0]      word;
        logic                       we;
        logic [BANK_DATA_WIDTH-1:0] wdata;
        logic [DATA_BYTE_NUM-1:0]   byte_en;
    } cpu_req_t;

    function automatic logic [BANK_DATA_WIDTH-1:0] line_word(
        input logic [WHOLE_DATA_WIDTH-1:0] line,
        input logic [WORD_OFF_W-1:0]       w
    );
        return line[BANK_DATA_WIDTH*w +: BANK_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/cache_valid_lru.sv
// Per-set valid bits (one per way) and LRU bit; LRU holds the way to evict next.
module cache_valid_lru
    import cache_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_WIDTH-1:0]    idx_i,
    input  logic                     set_valid_i,
    input  logic                     set_way_i,
    input  logic                     lru_we_i,
    input  logic                     lru_way_i,
    output logic [CACHE_WAY_NUM-1:0] valid_o,
    output logic                     lru_o
);

    logic [CACHE_WAY_NUM-1:0] valid_q [SET_NUM];
    logic [SET_NUM-1:0]       lru_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SET_NUM); i++) begin
                valid_q[i] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (set_valid_i) begin
                valid_q[idx_i][set_way_i] <= 1'b1;
            end
            if (lru_we_i) begin
                lru_q[idx_i] <= lru_way_i;
            end
        end
    end

    assign valid_o = valid_q[idx_i];
    assign lru_o   = lru_q[idx_i];

endmodule

// File: rtl/cache_2way_ctrl.sv
// Write-through, no-write-allocate controller for a 2-way set-associative
// storage array: lookup, LRU victim choice and line refill.
module cache_2way_ctrl
    import cache_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [31:0]                 cpu_addr,
    input  logic [BANK_DATA_WIDTH-1:0]  cpu_wdata,
    input  logic [DATA_BYTE_NUM-1:0]    cpu_byte_en,
    output logic [BANK_DATA_WIDTH-1:0]  cpu_rdata,
    output logic                        cpu_ready,
    output logic                        wr_en,
    output logic                        wr_tag_en,
    output logic [CACHE_WAY_NUM-1:0]    way_select,
    output logic [ADDR_WIDTH-1:0]       addr,
    output logic [WHOLE_DATA_WIDTH-1:0] wr_data,
    output logic [TAG_BITS-1:0]         wr_tag,
    output logic [DATA_WORD_NUM-1:0]    wr_word_en,
    output logic [DATA_BYTE_NUM-1:0]    wr_byte_en,
    input  logic [TAG_BITS-1:0]         tag_data_way0,
    input  logic [TAG_BITS-1:0]         tag_data_way1,
    input  logic [WHOLE_DATA_WIDTH-1:0] rd_data_way0,
    input  logic [WHOLE_DATA_WIDTH-1:0] rd_data_way1,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [BANK_DATA_WIDTH-1:0]  mem_wdata,
    output logic [DATA_BYTE_NUM-1:0]    mem_byte_en,
    input  logic [WHOLE_DATA_WIDTH-1:0] mem_rdata,
    input  logic                        mem_ack
);

    state_e                      state_q, state_d;
    cpu_req_t                    req_q, req_d;
    logic                        victim_q, victim_d;
    logic [WHOLE_DATA_WIDTH-1:0] line_q, line_d;

    logic [CACHE_WAY_NUM-1:0] valid;
    logic                     lru;
    logic                     set_valid, lru_we, lru_way;
    logic                     hit0, hit1, victim_c;
    logic                     unused_byte_off;

    assign unused_byte_off = ^cpu_addr[BYTE_OFF_W-1:0];

    cache_valid_lru u_valid_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (req_q.index),
        .set_valid_i (set_valid),
        .set_way_i   (victim_q),
        .lru_we_i    (lru_we),
        .lru_way_i   (lru_way),
        .valid_o     (valid),
        .lru_o       (lru)
    );

    assign hit0     = valid[0] && (tag_data_way0 == req_q.tag);
    assign hit1     = valid[1] && (tag_data_way1 == req_q.tag);
    // Fill an empty way first (way0 preferred); only then evict the LRU way.
    assign victim_c = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            victim_q <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            victim_q <= victim_d;
            line_q   <= line_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        victim_d    = victim_q;
        line_d      = line_q;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        wr_en       = 1'b0;
        wr_tag_en   = 1'b0;
        way_select  = '0;
        addr        = req_q.index;
        wr_data     = '0;
        wr_tag      = '0;
        wr_word_en  = '0;
        wr_byte_en  = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_byte_en = '0;
        set_valid   = 1'b0;
        lru_we      = 1'b0;
        lru_way     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Present the index early so the array read lands in LOOKUP.
                addr = cpu_addr[INDEX_LSB +: ADDR_WIDTH];
                if (cpu_req) begin
                    req_d.tag     = cpu_addr[TAG_LSB +: TAG_BITS];
                    req_d.index   = cpu_addr[INDEX_LSB +: ADDR_WIDTH];
                    req_d.word    = cpu_addr[BYTE_OFF_W +: WORD_OFF_W];
                    req_d.we      = cpu_we;
                    req_d.wdata   = cpu_wdata;
                    req_d.byte_en = cpu_byte_en;
                    state_d       = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit0 || hit1) begin
                    lru_we  = 1'b1;
                    lru_way = !hit1;
                    if (req_q.we) begin
                        wr_en      = 1'b1;
                        way_select = hit1 ? WAY1 : WAY0;
                        wr_word_en = DATA_WORD_NUM'(1) << req_q.word;
                        wr_byte_en = req_q.byte_en;
                        wr_data    = {DATA_WORD_NUM{req_q.wdata}};
                        state_d    = ST_WRMEM;
                    end else begin
                        cpu_ready = 1'b1;
                        cpu_rdata = line_word(hit1 ? rd_data_way1 : rd_data_way0, req_q.word);
                        state_d   = ST_IDLE;
                    end
                end else if (req_q.we) begin
                    state_d = ST_WRMEM;
                end else begin
                    victim_d = victim_c;
                    state_d  = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_q.tag, req_q.index, (WORD_OFF_W + BYTE_OFF_W)'(0)};
                if (mem_ack) begin
                    line_d  = mem_rdata;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                wr_en      = 1'b1;
                wr_tag_en  = 1'b1;
                way_select = victim_q ? WAY1 : WAY0;
                wr_word_en = '1;
                wr_byte_en = '1;
                wr_data    = line_q;
                wr_tag     = req_q.tag;
                set_valid  = 1'b1;
                lru_we     = 1'b1;
                lru_way    = !victim_q;
                cpu_ready  = 1'b1;
                cpu_rdata  = line_word(line_q, req_q.word);
                state_d    = ST_IDLE;
            end
            ST_WRMEM: begin
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = {req_q.tag, req_q.index, req_q.word, BYTE_OFF_W'(0)};
                mem_wdata   = req_q.wdata;
                mem_byte_en = req_q.byte_en;
                if (mem_ack) begin
                    cpu_ready = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Randomised bench for cache_2way_ctrl: storage array and memory models plus
// an abstract cache/memory reference that predicts every transaction.
module tb_cache_2way_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]   cpu_byte_en = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         wr_en, wr_tag_en;
    logic [1:0]   way_select;
    logic [4:0]   addr;
    logic [127:0] wr_data;
    logic [22:0]  wr_tag;
    logic [3:0]   wr_word_en, wr_byte_en;
    logic [22:0]  tag_data_way0 = '0, tag_data_way1 = '0;
    logic [127:0] rd_data_way0 = '0, rd_data_way1 = '0;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata;
    logic [3:0]   mem_byte_en;
    logic [127:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_2way_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .wr_en(wr_en), .wr_tag_en(wr_tag_en), .way_select(way_select), .addr(addr),
        .wr_data(wr_data), .wr_tag(wr_tag), .wr_word_en(wr_word_en), .wr_byte_en(wr_byte_en),
        .tag_data_way0(tag_data_way0), .tag_data_way1(tag_data_way1),
        .rd_data_way0(rd_data_way0), .rd_data_way1(rd_data_way1),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Storage array: synchronous read of addr, masked posedge write; not reset.
    logic [127:0] sto_data [32][2];
    logic [22:0]  sto_tag  [32][2];
    logic         sto_way;
    assign sto_way = way_select[1];

    initial begin
        for (int s = 0; s < 32; s++) begin
            for (int w = 0; w < 2; w++) begin
                sto_data[s][w] = '0;
                sto_tag[s][w]  = 23'($urandom);
            end
        end
    end

    always @(posedge clk) begin
        if (wr_en) begin
            for (int wd = 0; wd < 4; wd++)
                for (int b = 0; b < 4; b++)
                    if (wr_word_en[wd] && wr_byte_en[b])
                        sto_data[addr][sto_way][wd*32+b*8 +: 8] <= wr_data[wd*32+b*8 +: 8];
        end
        if (wr_tag_en) sto_tag[addr][sto_way] <= wr_tag;
        rd_data_way0  <= sto_data[addr][0];
        rd_data_way1  <= sto_data[addr][1];
        tag_data_way0 <= sto_tag[addr][0];
        tag_data_way1 <= sto_tag[addr][1];
    end

    // Reference: cache directory per set plus a flat word-addressed memory image.
    bit          ref_valid [32][2];
    int          ref_tag   [32][2];
    int          ref_lru   [32];
    logic [31:0] mem_m [int unsigned];

    function automatic logic [31:0] mem_rd(input int unsigned wa);
        if (mem_m.exists(wa)) return mem_m[wa];
        return (wa * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic ref_clear();
        for (int s = 0; s < 32; s++) begin
            ref_valid[s][0] = 1'b0;
            ref_valid[s][1] = 1'b0;
            ref_lru[s] = 0;
        end
    endtask

    // One CPU transaction; d = extra memory wait cycles before mem_ack.
    // Latency counts clock cycles after the one in which cpu_req is sampled.
    task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input int d);
        int idx, tg, hw, vic, exp_lat, lat, waitc;
        int unsigned wa;
        logic [31:0] exp_rd, got_rd, m_addr, m_wd, exp_maddr;
        logic [127:0] line, w_dat;
        logic [3:0] m_be, w_we, w_be;
        logic [22:0] w_tag;
        logic [1:0] w_way;
        bit saw_mem, saw_wr, saw_tagwr, done, m_we, exp_mem, exp_wr;
        idx = int'(a[8:4]);
        tg  = int'(a[31:9]);
        wa  = a >> 2;
        hw  = -1;
        for (int w = 0; w < 2; w++)
            if (ref_valid[idx][w] && ref_tag[idx][w] == tg) hw = w;
        if (!ref_valid[idx][0]) vic = 0;
        else if (!ref_valid[idx][1]) vic = 1;
        else vic = ref_lru[idx];
        exp_rd = mem_rd(wa);
        for (int k = 0; k < 4; k++) line[k*32 +: 32] = mem_rd((wa & ~32'd3) + 32'(k));
        exp_lat   = we ? 2 + d : ((hw >= 0) ? 1 : 3 + d);
        exp_mem   = we || (hw < 0);
        exp_wr    = we ? (hw >= 0) : (hw < 0);
        exp_maddr = we ? {a[31:2], 2'b00} : {a[31:4], 4'b0000};

        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_byte_en = be;
        lat = 0; waitc = 0; done = 0; saw_mem = 0; saw_wr = 0; saw_tagwr = 0;
        got_rd = '0; m_addr = '0; m_wd = '0; m_be = '0; m_we = 0;
        w_dat = '0; w_we = '0; w_be = '0; w_tag = '0; w_way = '0;
        while (!done && lat < 60) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!saw_mem) begin
                    m_addr = mem_addr; m_we = mem_we; m_wd = mem_wdata; m_be = mem_byte_en;
                end
                saw_mem = 1;
                if (waitc == d) begin
                    mem_ack = 1'b1;
                    mem_rdata = line;
                end
                waitc++;
            end
            #1;
            if (wr_en && !saw_wr) begin
                saw_wr = 1; w_way = way_select; w_we = wr_word_en; w_be = wr_byte_en;
                w_dat = wr_data; w_tag = wr_tag;
            end
            if (wr_tag_en) saw_tagwr = 1;
            if (cpu_ready) begin
                done = 1;
                got_rd = cpu_rdata;
            end
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        cpu_req = 1'b0;

        if (!done) begin
            errors++;
            $display("FAIL timeout addr=%h: no cpu_ready within 60 cycles", a);
        end else begin
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL latency addr=%h we=%0d: got %0d expected %0d", a, we, lat, exp_lat);
            end
            if (!we) begin
                checks++;
                if (got_rd !== exp_rd) begin
                    errors++;
                    $display("FAIL rdata addr=%h: got %h expected %h", a, got_rd, exp_rd);
                end
            end
        end
        checks++;
        if (saw_mem !== exp_mem) begin
            errors++;
            $display("FAIL mem_req_seen addr=%h: got %0d expected %0d", a, saw_mem, exp_mem);
        end
        if (saw_mem && exp_mem) begin
            checks++;
            if (m_addr !== exp_maddr || m_we !== we) begin
                errors++;
                $display("FAIL mem_addr addr=%h: got %h/we%0d expected %h/we%0d", a, m_addr, m_we, exp_maddr, we);
            end
            if (we) begin
                checks++;
                if (m_wd !== wd || m_be !== be) begin
                    errors++;
                    $display("FAIL mem_wdata addr=%h: got %h/%b expected %h/%b", a, m_wd, m_be, wd, be);
                end
            end
        end
        checks++;
        if (saw_wr !== exp_wr) begin
            errors++;
            $display("FAIL array_write_seen addr=%h we=%0d: got %0d expected %0d", a, we, saw_wr, exp_wr);
        end
        if (saw_wr && exp_wr && !we) begin
            checks++;
            if (w_way !== (vic ? 2'b10 : 2'b01) || !saw_tagwr || w_tag !== 23'(tg) ||
                w_dat !== line || w_we !== 4'hF || w_be !== 4'hF) begin
                errors++;
                $display("FAIL fill addr=%h: way %b tag %h wen %b ben %b tagwr %0d expected way %b tag %h",
                         a, w_way, w_tag, w_we, w_be, saw_tagwr, (vic ? 2'b10 : 2'b01), 23'(tg));
            end
        end
        if (saw_wr && exp_wr && we) begin
            checks++;
            if (w_way !== (hw == 1 ? 2'b10 : 2'b01) || saw_tagwr || w_we !== (4'b0001 << a[3:2]) ||
                w_be !== be || w_dat !== {4{wd}}) begin
                errors++;
                $display("FAIL write_hit addr=%h: way %b wen %b ben %b tagwr %0d expected way %b wen %b ben %b",
                         a, w_way, w_we, w_be, saw_tagwr, (hw == 1 ? 2'b10 : 2'b01), 4'b0001 << a[3:2], be);
            end
        end

        if (we) begin
            logic [31:0] old;
            old = mem_rd(wa);
            for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = wd[b*8 +: 8];
            mem_m[wa] = old;
            if (hw >= 0) ref_lru[idx] = 1 - hw;
        end else if (hw >= 0) begin
            ref_lru[idx] = 1 - hw;
        end else begin
            ref_valid[idx][vic] = 1'b1;
            ref_tag[idx][vic]   = tg;
            ref_lru[idx]        = 1 - vic;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ref_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_ready, mem_req, mem_we, wr_en, wr_tag_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {cpu_ready, mem_req, mem_we, wr_en, wr_tag_en});
        end
        checks++;
        if ({way_select, wr_word_en, wr_byte_en, mem_addr, wr_tag} !== '0) begin
            errors++;
            $display("FAIL reset_data: way %b wen %b mem_addr %h expected all zero", way_select, wr_word_en, mem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_access(0, 32'h0000_0010, 32'h0, 4'h0, 0);
        do_access(0, 32'h0000_0010, 32'h0, 4'h0, 0);
        do_access(0, 32'h0000_0210, 32'h0, 4'h0, 1);
        do_access(0, 32'h0000_0410, 32'h0, 4'h0, 2);
        do_access(0, 32'h0000_0214, 32'h0, 4'h0, 0);
        do_access(1, 32'h0000_0418, 32'hDEAD_BEEF, 4'b0011, 1);
        do_access(0, 32'h0000_0418, 32'h0, 4'h0, 0);
        do_access(1, 32'h0000_0818, 32'h1234_5678, 4'b1100, 0);
        do_access(0, 32'h0000_0818, 32'h0, 4'h0, 0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++)
            do_access(n[0], 32'h0000_0C20 + 32'(n[1:0]) * 32'h200, 32'($urandom), 4'hF, n % 3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 160; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 3) << 9) | 32'($urandom_range(0, 2) << 4) |
                32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom);
            do_access($urandom_range(0, 9) < 3, a, 32'($urandom), 4'($urandom_range(1, 15)),
                      int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0A50;
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = mem_req;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_setup: mem_req got 0 expected 1");
        end
        #1 rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: mem_req %b ready %b wr_en %b expected 000", mem_req, cpu_ready, wr_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ref_clear();
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = {4{32'hBAD0_BAD0}};
        #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: mem_req %b ready %b expected 00", mem_req, cpu_ready);
        end
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || wr_en !== 1'b0 || cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL late_ack_idle: mem_req %b wr_en %b ready %b expected 000", mem_req, wr_en, cpu_ready);
        end
        do_access(0, 32'h0000_0A50, 32'h0, 4'h0, 1);
        do_access(0, 32'h0000_0010, 32'h0, 4'h0, 0);
        do_access(0, 32'h0000_0A54, 32'h0, 4'h0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
